// File: rtl/memory_stage.sv
// Y86-64 memory stage: the M pipeline register, the byte-addressed data
// memory with its preload port, and the W pipeline register for writeback.
module memory_stage #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        M_stall,
  input  logic        M_bubble,
  input  logic        W_stall,
  input  logic        load_en,
  input  logic [63:0] load_addr,
  input  logic [7:0]  load_data,
  output logic [63:0] m_valM,
  output logic [3:0]  m_stat,
  output logic [3:0]  M_icode,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] M_valE,
  output logic        M_Cnd,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM
);

  localparam int          AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MEM_SIZE = 64'(MEM_BYTES);
  localparam logic [63:0] LAST_OK  = 64'(MEM_BYTES - 8);

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_ADR = 4'h3;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] REG_NONE = 4'hF;

  logic [3:0]    M_stat;
  logic [63:0]   M_valA;
  logic [7:0]    mem [MEM_BYTES];

  logic [63:0]   mem_addr;
  logic          rd_en;
  logic          wr_en;
  logic          dmem_error;
  logic          store_en;
  logic [AW-1:0] base;
  logic [63:0]   rd_data;

  // M register: stall holds, bubble inserts a NOP, otherwise capture execute
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= 64'd0;
      M_valA  <= 64'd0;
      M_dstE  <= REG_NONE;
      M_dstM  <= REG_NONE;
    end else if (!M_stall) begin
      if (M_bubble) begin
        M_stat  <= STAT_AOK;
        M_icode <= I_NOP;
        M_Cnd   <= 1'b0;
        M_valE  <= 64'd0;
        M_valA  <= 64'd0;
        M_dstE  <= REG_NONE;
        M_dstM  <= REG_NONE;
      end else begin
        M_stat  <= e_stat;
        M_icode <= e_icode;
        M_Cnd   <= e_Cnd;
        M_valE  <= e_valE;
        M_valA  <= e_valA;
        M_dstE  <= e_dstE;
        M_dstM  <= e_dstM;
      end
    end
  end

  // Address source and access direction decoded from the instruction in M
  always_comb begin
    mem_addr = 64'd0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    case (M_icode)
      4'h4, 4'h8, 4'hA: begin
        mem_addr = M_valE;
        wr_en    = 1'b1;
      end
      4'h5: begin
        mem_addr = M_valE;
        rd_en    = 1'b1;
      end
      4'h9, 4'hB: begin
        mem_addr = M_valA;
        rd_en    = 1'b1;
      end
      default: ;
    endcase
  end

  // Full 64-bit compare so addresses near 2^64 cannot wrap into range
  assign dmem_error = (rd_en || wr_en) && (mem_addr > LAST_OK);
  assign base       = mem_addr[AW-1:0];
  assign m_stat     = dmem_error ? STAT_ADR : M_stat;
  // A store commits only when neither this instruction nor the one ahead of it is abnormal
  assign store_en   = wr_en && !dmem_error && (M_stat == STAT_AOK) && (W_stat == STAT_AOK);

  // Little-endian 8-byte read; unaligned bases are fine
  always_comb begin
    rd_data = 64'd0;
    for (int i = 0; i < 8; i++) begin
      rd_data[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  assign m_valM = (rd_en && !dmem_error) ? rd_data : 64'd0;

  // Data memory writes: pipeline store first, preload last so it wins a byte collision
  always_ff @(posedge clock) begin
    if (store_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= M_valA[8*i +: 8];
      end
    end
    if (load_en && (load_addr < MEM_SIZE)) begin
      mem[load_addr[AW-1:0]] <= load_data;
    end
  end

  // W register: stall holds, otherwise capture the memory-stage results
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      W_stat  <= STAT_AOK;
      W_icode <= I_NOP;
      W_valE  <= 64'd0;
      W_valM  <= 64'd0;
      W_dstE  <= REG_NONE;
      W_dstM  <= REG_NONE;
    end else if (!W_stall) begin
      W_stat  <= m_stat;
      W_icode <= M_icode;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: vector table through a W-stage scoreboard, plus
// directed sequences for reset, stalls, preload collisions and dropped stores.
module tb_memory_stage;

  localparam int MEM_BYTES = 4096;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  e_stat, e_icode, e_dstE, e_dstM;
  logic        e_Cnd;
  logic [63:0] e_valE, e_valA;
  logic        M_stall, M_bubble, W_stall;
  logic        load_en;
  logic [63:0] load_addr;
  logic [7:0]  load_data;
  logic [63:0] m_valM, M_valE, W_valE, W_valM;
  logic [3:0]  m_stat, M_icode, M_dstE, M_dstM;
  logic        M_Cnd;
  logic [3:0]  W_stat, W_icode, W_dstE, W_dstM;

  memory_stage #(.MEM_BYTES(MEM_BYTES)) dut (
    .clock(clock), .reset(reset),
    .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd), .e_valE(e_valE), .e_valA(e_valA),
    .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stall(M_stall), .M_bubble(M_bubble), .W_stall(W_stall),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .m_valM(m_valM), .m_stat(m_stat),
    .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .M_Cnd(M_Cnd),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  x_stat;
    logic [63:0] x_valM;
  } vec_t;

  typedef struct {
    int          due;
    int          row;
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valE;
    logic [63:0] valM;
  } exp_t;

  vec_t vt[16];
  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   cycle  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic score();
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cycle) begin
      e = sb.pop_front();
      chk($sformatf("row%0d_W_stat", e.row), 64'(W_stat), 64'(e.stat));
      chk($sformatf("row%0d_W_valM", e.row), W_valM, e.valM);
      chk($sformatf("row%0d_W_fields", e.row),
          {W_valE, W_icode, W_dstE, W_dstM}, {e.valE, e.icode, e.dstE, e.dstM});
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cycle++;
    score();
  endtask

  task automatic set_e(input logic [3:0] s, input logic [3:0] i, input logic c,
                       input logic [63:0] ve, input logic [63:0] va,
                       input logic [3:0] de, input logic [3:0] dm);
    e_stat = s; e_icode = i; e_Cnd = c; e_valE = ve; e_valA = va; e_dstE = de; e_dstM = dm;
  endtask

  task automatic idle();
    set_e(4'h1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF);
  endtask

  task automatic preload(input logic [63:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] s, input logic [3:0] i,
                              input logic [63:0] ve, input logic [63:0] va,
                              input logic [3:0] de, input logic [3:0] dm,
                              input logic [3:0] xs, input logic [63:0] xm);
    vec_t v;
    v.stat = s; v.icode = i; v.valE = ve; v.valA = va; v.dstE = de; v.dstM = dm;
    v.x_stat = xs; v.x_valM = xm;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vt[0]  = mk(1, 4'h4, 64'h100, 64'h1122334455667788, 4'hF, 4'hF, 1, 64'h0);
    vt[1]  = mk(1, 4'h5, 64'h100, 64'h0, 4'hF, 4'h3, 1, 64'h1122334455667788);
    vt[2]  = mk(1, 4'h5, 64'h101, 64'h0, 4'hF, 4'h3, 1, 64'h0011223344556677);
    vt[3]  = mk(1, 4'h5, 64'hFF8, 64'h0, 4'hF, 4'h3, 1, 64'hAB00000000000000);
    vt[4]  = mk(1, 4'h5, 64'hFF9, 64'h0, 4'hF, 4'h3, 3, 64'h0);
    vt[5]  = mk(1, 4'h5, 64'hFFFFFFFFFFFFFFFC, 64'h0, 4'hF, 4'h3, 3, 64'h0);
    vt[6]  = mk(1, 4'hA, 64'h1000, 64'h55, 4'h4, 4'hF, 3, 64'h0);
    vt[7]  = mk(2, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 2, 64'h0);
    vt[8]  = mk(1, 4'hA, 64'h300, 64'hDEADBEEFDEADBEEF, 4'h4, 4'hF, 1, 64'h0);
    vt[9]  = mk(1, 4'h5, 64'h300, 64'h0, 4'hF, 4'h6, 1, 64'h0);
    vt[10] = mk(1, 4'h5, 64'hFF8, 64'h0, 4'hF, 4'h6, 1, 64'hAB00000000000000);
    vt[11] = mk(1, 4'hA, 64'h200, 64'hAAAAAAAAAAAAAAAA, 4'h4, 4'hF, 1, 64'h0);
    vt[12] = mk(1, 4'hB, 64'h208, 64'h200, 4'h4, 4'h7, 1, 64'hAAAAAAAAAAAAAAAA);
    vt[13] = mk(1, 4'h9, 64'h210, 64'h100, 4'h4, 4'hF, 1, 64'h1122334455667788);
    vt[14] = mk(1, 4'h6, 64'h12345, 64'h100, 4'h2, 4'hF, 1, 64'h0);
    vt[15] = mk(4, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 4, 64'h0);

    // Reset with random inputs: registers go to bubble without a clock edge
    reset = 1'b1; M_stall = 1'b0; M_bubble = 1'b0; W_stall = 1'b0;
    load_en = 1'b0; load_addr = 64'd0; load_data = 8'd0;
    set_e(4'($urandom), 4'($urandom), 1'b1, {$urandom, $urandom}, {$urandom, $urandom},
          4'($urandom), 4'($urandom));
    #1 reset = 1'b0;
    #1;
    chk("rst_M_icode", 64'(M_icode), 64'h1);
    chk("rst_M_regs", {M_valE, M_dstE, M_dstM, 3'b0, M_Cnd}, {64'h0, 4'hF, 4'hF, 4'h0});
    chk("rst_m_stat", 64'(m_stat), 64'h1);
    chk("rst_W_stat", 64'(W_stat), 64'h1);
    chk("rst_W_icode", 64'(W_icode), 64'h1);
    chk("rst_W_dst", {W_dstE, W_dstM}, {4'hF, 4'hF});
    chk("rst_W_vals", {W_valE, W_valM}, 128'h0);
    repeat (2) tick();
    chk("rst_held_M_icode", 64'(M_icode), 64'h1);
    idle();
    reset = 1'b1;

    // Known contents for every region read back later
    for (int a = 'h100; a < 'h110; a++) preload(64'(a), 8'h00);
    for (int a = 'h300; a < 'h308; a++) preload(64'(a), 8'h00);
    for (int a = 'h500; a < 'h508; a++) preload(64'(a), 8'h00);
    for (int a = 'hFF8; a < 'hFFF; a++) preload(64'(a), 8'h00);
    preload(64'hFFF, 8'hAB);

    // Vector table, back to back, checked at W two edges after drive
    for (int k = 0; k < 16; k++) begin
      set_e(vt[k].stat, vt[k].icode, 1'b0, vt[k].valE, vt[k].valA, vt[k].dstE, vt[k].dstM);
      e.due = cycle + 2; e.row = k;
      e.stat = vt[k].x_stat; e.icode = vt[k].icode; e.dstE = vt[k].dstE; e.dstM = vt[k].dstM;
      e.valE = vt[k].valE; e.valM = vt[k].x_valM;
      sb.push_back(e);
      tick();
    end
    idle();
    for (int n = 0; n < 10 && sb.size() > 0; n++) tick();
    if (sb.size() > 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end

    // M_stall has priority over M_bubble; M_bubble alone inserts a NOP
    set_e(1, 4'h6, 1'b1, 64'h11, 64'h0, 4'h5, 4'hF);
    tick();
    chk("load_M", {M_icode, M_dstE, 3'b0, M_Cnd, M_valE}, {4'h6, 4'h5, 4'h1, 64'h11});
    set_e(1, 4'h2, 1'b0, 64'h22, 64'h0, 4'h7, 4'hF);
    M_stall = 1'b1; M_bubble = 1'b1;
    tick();
    chk("stall_bubble_M_holds", {M_icode, M_dstE, M_valE}, {4'h6, 4'h5, 64'h11});
    M_stall = 1'b0;
    tick();
    chk("bubble_M", {M_icode, M_dstE, M_dstM, M_valE}, {4'h1, 4'hF, 4'hF, 64'h0});
    M_bubble = 1'b0;

    // W_stall holds W while M keeps moving
    set_e(1, 4'h6, 1'b0, 64'h33, 64'h0, 4'h4, 4'hF);
    tick();
    set_e(1, 4'h6, 1'b0, 64'h44, 64'h0, 4'h4, 4'hF);
    tick();
    chk("W_before_stall", {W_icode, W_valE}, {4'h6, 64'h33});
    W_stall = 1'b1;
    tick();
    chk("W_stall_1", {W_icode, W_valE}, {4'h6, 64'h33});
    tick();
    chk("W_stall_2", {W_icode, W_valE}, {4'h6, 64'h33});
    W_stall = 1'b0;
    tick();
    chk("W_after_stall", W_valE, 64'h44);
    idle();
    repeat (2) tick();

    // Preload collides with one byte of a store; preload byte wins
    set_e(1, 4'hA, 1'b0, 64'h600, 64'h0102030405060708, 4'h4, 4'hF);
    tick();
    idle();
    load_en = 1'b1; load_addr = 64'h602; load_data = 8'hEE;
    tick();
    load_en = 1'b0;
    set_e(1, 4'h5, 1'b0, 64'h600, 64'h0, 4'hF, 4'h3);
    tick();
    chk("collision_read", m_valM, 64'h0102030405EE0708);
    chk("collision_m_stat", 64'(m_stat), 64'h1);
    // Read in the same cycle as a preload sees the old byte
    load_en = 1'b1; load_addr = 64'h600; load_data = 8'h99;
    #1;
    chk("rdw_old_data", m_valM, 64'h0102030405EE0708);
    tick();
    chk("rdw_new_data", m_valM, 64'h0102030405EE0799);
    // Out-of-range preload must not alias into the array
    load_addr = 64'h1601; load_data = 8'h55;
    tick();
    load_en = 1'b0;
    chk("oob_preload_ignored", m_valM, 64'h0102030405EE0799);
    idle();
    repeat (2) tick();

    // Reset while a store sits in M drops the store
    set_e(1, 4'h4, 1'b0, 64'h500, 64'h7777777777777777, 4'hF, 4'hF);
    tick();
    idle();
    chk("store_in_M", 64'(M_icode), 64'h4);
    #2 reset = 1'b0;
    #1;
    chk("midrst_M_icode", 64'(M_icode), 64'h1);
    chk("midrst_W_stat", 64'(W_stat), 64'h1);
    tick();
    reset = 1'b1;
    set_e(1, 4'h5, 1'b0, 64'h500, 64'h0, 4'hF, 4'h3);
    tick();
    chk("dropped_store_read", m_valM, 64'h0);
    chk("dropped_store_m_stat", 64'(m_stat), 64'h1);
    idle();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
